io_tx_buffer: RTL and testbench

//  Sits directly downstream of the cpu top's memory bus (mem_a/mem_dout/mem_wr).

---
 rtl/io_tx_buffer.sv | 176 +++++++++++++++++
 tb/tb_io_tx_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_tx_buffer.sv
// ----------------------------------------------------------------------------
// io_tx_buffer
//
// Snoops CPU bus writes to the I/O window. Output bytes written to offset 0x0
// are queued in a FIFO and drained to the UART transmitter over a valid/ready
// link. A write to offset 0x4 starts the program-stop sequence:
//   1. drain the queue,
//   2. send one NUL byte,
//   3. raise prog_stop.
//
// Ports
//   clk_in          single clock
//   rst_in          asynchronous, active-low reset
//   rdy_in          cpu ready; bus writes are only decoded while high
//   mem_a           cpu address; window select is mem_a[17:16] == 2'b11
//   mem_dout        cpu write data
//   mem_wr          cpu write strobe
//   io_buffer_full  registered back-pressure to the cpu
//   tx_data         byte presented to the UART (registered)
//   tx_valid        tx_data valid (registered)
//   tx_ready        UART accepts tx_data this cycle
//   overflow        sticky: a byte was dropped because the queue was full
//   prog_stop       sticky: stop sequence finished
// ----------------------------------------------------------------------------
module io_tx_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic        prog_stop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_CNT = CNT_W'(FULL_MARGIN);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SEND_NUL,
        HALTED
    } state_t;

    state_t state_q, state_d;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d, free_d;
    logic [7:0]            head_d, tx_data_d;
    logic                  tx_valid_d;
    logic                  io_sel, push_req, stop_req, push, pop, drop_full;

    // Upper and middle address bits are outside the decode.
    logic unused_addr;
    assign unused_addr = ^{mem_a[31:18], mem_a[15:3]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign io_sel   = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
    assign push_req = io_sel && (mem_a[2:0] == 3'h0) && (mem_dout != 8'h00);
    assign stop_req = io_sel && (mem_a[2:0] == 3'h4);

    // The NUL sent in SEND_NUL is not a queue entry, so it never pops.
    assign pop = tx_valid && tx_ready && (count_q != '0);

    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push      = push_req && (state_q == RUN) && ((count_q != DEPTH_CNT) || pop);
    assign drop_full = push_req && (state_q == RUN) && (count_q == DEPTH_CNT) && !pop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    assign free_d   = DEPTH_CNT - count_d;

    // Head of the queue after this edge. If no old entry remains, the head is
    // the byte being pushed now. Otherwise it is the oldest stored entry,
    // which a same-cycle push never overwrites.
    always_comb begin
        head_d = mem[rd_ptr_d];
        if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) begin
            head_d = mem_dout;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (stop_req)            state_d = DRAIN;
            DRAIN:    if (count_q == '0)       state_d = SEND_NUL;
            SEND_NUL: if (tx_valid && tx_ready) state_d = HALTED;
            HALTED:   state_d = HALTED;
        endcase
    end

    // The output register shows the next head. In SEND_NUL it shows the NUL
    // terminator. It holds its value while the UART stalls, because head_d
    // does not change without a pop.
    always_comb begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        if (state_d == SEND_NUL) begin
            tx_valid_d = 1'b1;
        end else if (count_d != '0) begin
            tx_valid_d = 1'b1;
            tx_data_d  = head_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the byte array has no reset. Only pointers and count are reset,
    // so stale contents are unreachable, and the array can map to plain RAM.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr_q] <= mem_dout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
            io_buffer_full <= 1'b0;
            overflow       <= 1'b0;
            prog_stop      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            tx_valid       <= tx_valid_d;
            tx_data        <= tx_data_d;
            io_buffer_full <= (state_d == HALTED) || (free_d <= MARGIN_CNT);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
            if (state_d == HALTED) begin
                prog_stop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_tx_buffer.sv
// ----------------------------------------------------------------------------
// tb_io_tx_buffer
//
// Self-checking bench for io_tx_buffer.
// Scenario tasks drive the bus and compare control outputs inline. When a
// task expects a byte to be emitted, it pushes that byte onto a scoreboard
// queue. A monitor pops the queue on every tx handshake and compares.
// Inputs change 1 ns after the rising edge. The monitor samples on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_io_tx_buffer;

    localparam logic [31:0] A_OUT  = 32'h0003_0000;
    localparam logic [31:0] A_STOP = 32'h0003_0004;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic        prog_stop;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb [$];

    always #5 clk_in = ~clk_in;

    io_tx_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .overflow       (overflow),
        .prog_stop      (prog_stop)
    );

    // Scoreboard monitor: each handshake must match the oldest expected byte.
    always @(negedge clk_in) begin : monitor
        logic [7:0] exp_b;
        if (rst_in === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data);
            end else begin
                exp_b = sb.pop_front();
                if (tx_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %02h, expected %02h", tx_data, exp_b);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d, input logic rdy);
        rdy_in   = rdy;
        mem_wr   = 1'b1;
        mem_a    = a;
        mem_dout = d;
        cycle();
        rdy_in   = 1'b1;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                return;
            end
            cycle();
        end
        ok = (sb.size() == 0);
    endtask

    task automatic apply_reset();
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        tx_ready = 1'b0;
        sb.delete();
        cycle();
        cycle();
        rst_in = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        rst_in   = 1'b0;
        rdy_in   = 1'b0;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        tx_ready = 1'b0;
        #12;
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
        n_checks++;
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h, expected 00", tx_data); end
        n_checks++;
        if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, expected 0", io_buffer_full); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        n_checks++;
        if (prog_stop !== 1'b0) begin n_fail++; $display("FAIL reset_prog_stop: got %b, expected 0", prog_stop); end
        cycle();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        cycle();
    endtask

    // Three bytes must stream out on consecutive cycles, the first one
    // cycle after its write.
    task automatic test_stream();
        logic [7:0] bytes [3];
        bytes[0] = 8'h41;
        bytes[1] = 8'h42;
        bytes[2] = 8'h43;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(bytes[i]);
            bus_write(A_OUT, bytes[i], 1'b1);
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== bytes[i]) begin
                n_fail++;
                $display("FAIL stream_head%0d: got valid=%b data=%02h, expected valid=1 data=%02h",
                         i, tx_valid, tx_data, bytes[i]);
            end
        end
        cycle();
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b, expected 0", tx_valid); end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL stream_left: got %0d bytes pending, expected 0", sb.size()); end
    endtask

    // Writes that must all be ignored:
    //   zero data to the output address,
    //   another window,
    //   another offset,
    //   a write while rdy_in is low.
    task automatic test_ignored();
        tx_ready = 1'b1;
        bus_write(A_OUT, 8'h00, 1'b1);
        bus_write(32'h0002_0000, 8'h55, 1'b1);
        bus_write(32'h0003_0002, 8'h56, 1'b1);
        bus_write(A_OUT, 8'h57, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ignored_valid%0d: got %b, expected 0", i, tx_valid); end
        end
        n_checks++;
        if (io_buffer_full !== 1'b0 || prog_stop !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_flags: got full=%b stop=%b, expected 0/0", io_buffer_full, prog_stop);
        end
    endtask

    // Full queue with push and pop in the same cycle: occupancy holds and
    // nothing is dropped. Exactly 19 bytes must come out in order.
    task automatic test_full_push_pop();
        bit ok;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'h80 + 8'(i));
            bus_write(A_OUT, 8'h80 + 8'(i), 1'b1);
        end
        n_checks++;
        if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL pp_full_before: got %b, expected 1", io_buffer_full); end
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(8'hC0 + 8'(k));
            bus_write(A_OUT, 8'hC0 + 8'(k), 1'b1);
        end
        n_checks++;
        if (io_buffer_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_flags: got full=%b overflow=%b, expected 1/0", io_buffer_full, overflow);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pp_drain_timeout: got %0d pending, expected 0", sb.size()); end
        cycle();
        n_checks++;
        if (tx_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_after: got valid=%b overflow=%b, expected 0/0", tx_valid, overflow);
        end
    endtask

    // Checks:
    //   io_buffer_full threshold at 14 entries,
    //   tx_data held stable while the UART stalls,
    //   drop of the 17th byte with the sticky overflow flag,
    //   in-order drain of the 16 stored bytes.
    task automatic test_overflow();
        bit ok;
        tx_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            sb.push_back(8'h10 + 8'(i));
            bus_write(A_OUT, 8'h10 + 8'(i), 1'b1);
            if (i == 12) begin
                n_checks++;
                if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full13: got %b, expected 0", io_buffer_full); end
            end
        end
        n_checks++;
        if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full14: got %b, expected 1", io_buffer_full); end
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin
            n_fail++;
            $display("FAIL ovf_hold: got valid=%b data=%02h, expected valid=1 data=10", tx_valid, tx_data);
        end
        for (int i = 14; i < 16; i++) begin
            sb.push_back(8'h10 + 8'(i));
            bus_write(A_OUT, 8'h10 + 8'(i), 1'b1);
        end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at16: got %b, expected 0", overflow); end
        bus_write(A_OUT, 8'h20, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_at17: got %b, expected 1", overflow); end
        tx_ready = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovf_drain_timeout: got %0d pending, expected 0", sb.size()); end
        cycle();
        n_checks++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after: got valid=%b full=%b overflow=%b, expected 0/0/1",
                     tx_valid, io_buffer_full, overflow);
        end
    endtask

    // Stop sequence: the five queued bytes, then NUL, then prog_stop.
    // Bytes written after the stop request are never sent.
    task automatic test_stop();
        bit ok;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h61 + 8'(i));
            bus_write(A_OUT, 8'h61 + 8'(i), 1'b1);
        end
        bus_write(A_STOP, 8'h01, 1'b1);
        n_checks++;
        if (prog_stop !== 1'b0) begin n_fail++; $display("FAIL stop_early: got %b, expected 0", prog_stop); end
        bus_write(A_OUT, 8'h77, 1'b1);
        sb.push_back(8'h00);
        tx_ready = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stop_drain_timeout: got %0d pending, expected 0", sb.size()); end
        n_checks++;
        if (prog_stop !== 1'b1 || io_buffer_full !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_halted: got stop=%b full=%b valid=%b, expected 1/1/0",
                     prog_stop, io_buffer_full, tx_valid);
        end
        bus_write(A_OUT, 8'h78, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        n_checks++;
        if (prog_stop !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_held: got stop=%b valid=%b, expected 1/0", prog_stop, tx_valid);
        end
    endtask

    // Reset mid-drain drops tx_valid immediately and empties the queue.
    task automatic test_reset_mid_drain();
        bit ok;
        apply_reset();
        tx_ready = 1'b0;
        sb.push_back(8'hA1);
        bus_write(A_OUT, 8'hA1, 1'b1);
        bus_write(A_OUT, 8'hA2, 1'b1);
        bus_write(A_OUT, 8'hA3, 1'b1);
        tx_ready = 1'b1;
        cycle();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA2) begin
            n_fail++;
            $display("FAIL rst_pre: got valid=%b data=%02h, expected valid=1 data=a2", tx_valid, tx_data);
        end
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b data=%02h, expected valid=0 data=00", tx_valid, tx_data);
        end
        sb.delete();
        cycle();
        cycle();
        rst_in = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0 || overflow !== 1'b0 || prog_stop !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got valid=%b full=%b ovf=%b stop=%b, expected all 0",
                     tx_valid, io_buffer_full, overflow, prog_stop);
        end
        sb.push_back(8'h5A);
        bus_write(A_OUT, 8'h5A, 1'b1);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_run: got valid=%b data=%02h, expected valid=1 data=5a", tx_valid, tx_data);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_drain_timeout: got %0d pending, expected 0", sb.size()); end
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_empty: got valid=%b, expected 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ignored();
        test_full_push_pop();
        test_overflow();
        test_stop();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
